// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: fetch-stage PC sequencer for the word-addressed pipeline.
// Owns the PC, drives the imem request handshake and feeds the IF/ID register.
module fetch_pc_ctrl #(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_base,
    input  logic [PC_W-1:0] redirect_offset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    output logic [PC_W-1:0] pc_out,
    output logic            if_valid,
    output logic [PC_W-1:0] if_pc,
    output logic [PC_W-1:0] if_npc,
    output logic            flush
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc_nxt;
    logic            xfer;
    logic            redir;
    logic            take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        unique case (state)
            BOOT: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                imem_req  = !stall;
                state_nxt = stall ? HOLD : FETCH;
            end
            HOLD: begin
                state_nxt = stall ? HOLD : FETCH;
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // A redirect wins over a concurrent transfer; the fetched word is dropped.
    assign xfer   = imem_req && imem_ack;
    assign redir  = redirect_valid && (state != BOOT);
    assign take   = xfer && !redir;
    assign pc_inc = pc + ONE;
    assign target = redirect_base + redirect_offset + ONE;

    always_comb begin
        pc_nxt = pc;
        if (redir) begin
            pc_nxt = target;
        end else if (take) begin
            pc_nxt = pc_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_npc   <= '0;
            flush    <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            if_valid <= take;
            flush    <= redir;
            if (take) begin
                if_pc  <= pc;
                if_npc <= pc_inc;
            end
        end
    end

    assign imem_addr = pc;
    assign pc_out    = pc;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl: two instances (RESET_PC 0 and all-ones)
// share directed and random stimulus; a monitor checks IF/ID outputs.
module tb_fetch_pc_ctrl;

    localparam int W = 32;

    typedef struct packed {
        logic          fl;
        logic [W-1:0]  pc;
        logic [W-1:0]  npc;
        int unsigned   due;
    } txn_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         stall = 1'b0;
    logic         rv = 1'b0;
    logic         ack = 1'b0;
    logic [W-1:0] base = '0;
    logic [W-1:0] off = '0;

    logic         req[2];
    logic [W-1:0] addr[2];
    logic [W-1:0] pco[2];
    logic         iv[2];
    logic [W-1:0] ipc[2];
    logic [W-1:0] inpc[2];
    logic         fl[2];

    fetch_pc_ctrl #(.PC_W(W), .RESET_PC(32'h0000_0000)) dut_a (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(rv), .redirect_base(base), .redirect_offset(off),
        .imem_req(req[0]), .imem_addr(addr[0]), .imem_ack(ack),
        .pc_out(pco[0]), .if_valid(iv[0]), .if_pc(ipc[0]),
        .if_npc(inpc[0]), .flush(fl[0])
    );

    fetch_pc_ctrl #(.PC_W(W), .RESET_PC(32'hFFFF_FFFF)) dut_b (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(rv), .redirect_base(base), .redirect_offset(off),
        .imem_req(req[1]), .imem_addr(addr[1]), .imem_ack(ack),
        .pc_out(pco[1]), .if_valid(iv[1]), .if_pc(ipc[1]),
        .if_npc(inpc[1]), .flush(fl[1])
    );

    always #5 clk = ~clk;

    txn_t         q0[$];
    txn_t         q1[$];
    logic [W-1:0] m_pc[2];
    bit           m_boot[2];
    bit           m_hold[2];
    logic [W-1:0] h_pc[2];
    logic [W-1:0] h_npc[2];
    int unsigned  cyc = 0;
    int           checks = 0;
    int           failures = 0;

    function automatic logic [W-1:0] rpc(int i);
        return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFFF;
    endfunction

    task automatic chk(string name, int i, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] cyc=%0d got=%h expected=%h", name, i, cyc, act, exp);
        end
    endtask

    function automatic void push(int i, txn_t t);
        if (i == 0) q0.push_back(t);
        else q1.push_back(t);
    endfunction

    function automatic int qsize(int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic txn_t qfront(int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void qpop(int i);
        if (i == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i]   = rpc(i);
            m_boot[i] = 1'b0;
            m_hold[i] = 1'b0;
            h_pc[i]   = '0;
            h_npc[i]  = '0;
        end
        q0.delete();
        q1.delete();
    endtask

    // Model: after the idle boot cycle, fetching is enabled in any cycle
    // whose previous cycle had stall low and whose current stall is low.
    task automatic step(bit s, bit r, logic [W-1:0] b, logic [W-1:0] o, bit a);
        bit   ereq;
        txn_t t;
        @(negedge clk);
        rst_n = 1'b1;
        stall = s;
        rv    = r;
        base  = b;
        off   = o;
        ack   = a;
        #1;
        for (int i = 0; i < 2; i++) begin
            ereq = m_boot[i] && !m_hold[i] && !s;
            chk("imem_req", i, W'(req[i]), W'(ereq));
            chk("imem_addr", i, addr[i], m_pc[i]);
            chk("pc_out", i, pco[i], m_pc[i]);
            if (m_boot[i] && r) begin
                t.fl = 1'b1; t.pc = '0; t.npc = '0; t.due = cyc + 1;
                push(i, t);
                m_pc[i] = b + o + 32'd1;
            end else if (ereq && a) begin
                t.fl = 1'b0; t.pc = m_pc[i]; t.npc = m_pc[i] + 32'd1; t.due = cyc + 1;
                push(i, t);
                m_pc[i] = m_pc[i] + 32'd1;
            end
            m_hold[i] = m_boot[i] ? s : 1'b0;
            m_boot[i] = 1'b1;
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            chk("rst_pc", i, pco[i], rpc(i));
            chk("rst_if_valid", i, W'(iv[i]), '0);
            chk("rst_flush", i, W'(fl[i]), '0);
            chk("rst_imem_req", i, W'(req[i]), '0);
            chk("rst_if_pc", i, ipc[i], '0);
        end
        @(posedge clk);
        @(posedge clk);
    endtask

    always @(posedge clk) begin
        txn_t t;
        cyc++;
        #2;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                chk("if_valid_in_rst", i, W'(iv[i]), '0);
                chk("flush_in_rst", i, W'(fl[i]), '0);
            end else if (iv[i] || fl[i]) begin
                if (qsize(i) == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out[%0d] cyc=%0d got valid=%0b flush=%0b expected none",
                             i, cyc, iv[i], fl[i]);
                end else begin
                    t = qfront(i);
                    qpop(i);
                    chk("due_cycle", i, W'(cyc), W'(t.due));
                    chk("flush", i, W'(fl[i]), W'(t.fl));
                    chk("if_valid", i, W'(iv[i]), W'(!t.fl));
                    if (!t.fl) begin
                        h_pc[i]  = t.pc;
                        h_npc[i] = t.npc;
                    end
                    chk("if_pc", i, ipc[i], h_pc[i]);
                    chk("if_npc", i, inpc[i], h_npc[i]);
                end
            end else begin
                if (qsize(i) != 0 && qfront(i).due <= cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL missing_out[%0d] cyc=%0d got none expected flush=%0b pc=%h",
                             i, cyc, qfront(i).fl, qfront(i).pc);
                    qpop(i);
                end
                chk("if_pc_hold", i, ipc[i], h_pc[i]);
                chk("if_npc_hold", i, inpc[i], h_npc[i]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got timeout expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit           s, r, a;
        logic [W-1:0] b, o;
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);

        repeat (6) step(1'b0, 1'b0, '0, '0, 1'b1);
        repeat (3) step(1'b1, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        repeat (11) step(1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b1, 32'h10, 32'hFFFF_FFFC, 1'b1);
        repeat (3) step(1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b1, 1'b1, 32'h100, 32'h20, 1'b1);
        step(1'b0, 1'b1, 32'h3F, 32'h0, 1'b1);
        reset_pulse();
        repeat (4) step(1'b0, 1'b0, '0, '0, 1'b1);

        repeat (3000) begin
            if ($urandom_range(0, 199) == 0) begin
                reset_pulse();
            end else begin
                s = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 9) == 0);
                a = ($urandom_range(0, 9) < 7);
                b = $urandom;
                if ($urandom_range(0, 3) == 0) o = $urandom;
                else o = W'($urandom_range(0, 40)) - 32'd20;
                step(s, r, b, o, a);
            end
        end

        step(1'b0, 1'b0, '0, '0, 1'b0);
        @(posedge clk);
        #3;
        for (int i = 0; i < 2; i++) begin
            chk("queue_drained", i, W'(qsize(i)), '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
